// File: rtl/dm_wb_cache_ctrl_pkg.sv
// dm_cache_pkg: shared constants, state encoding and block/word helpers for the write-back cache
package dm_cache_pkg;

    localparam int BLK_W  = 128;
    localparam int WORD_W = 32;
    localparam int OFF_W  = 4;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] COMPARE   = 2'd1;
    localparam logic [1:0] WRITEBACK = 2'd2;
    localparam logic [1:0] ALLOCATE  = 2'd3;

    // word 0 sits in the most significant lane of a block
    function automatic logic [WORD_W-1:0] getWord(input logic [BLK_W-1:0] blk, input logic [1:0] sel);
        return blk[WORD_W*(3-int'(sel)) +: WORD_W];
    endfunction

    function automatic logic [BLK_W-1:0] putWord(input logic [BLK_W-1:0] blk, input logic [1:0] sel,
                                                 input logic [WORD_W-1:0] w);
        logic [BLK_W-1:0] b;
        b = blk;
        b[WORD_W*(3-int'(sel)) +: WORD_W] = w;
        return b;
    endfunction

endpackage

// File: rtl/dm_wb_cache_ctrl_if.sv
// dm_wb_cache_ctrl_if: CPU request/response and block-memory signals of the cache controller
interface dm_wb_cache_ctrl_if
    import dm_cache_pkg::*;
#(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              resp_valid;
    logic [WORD_W-1:0] resp_rdata;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [BLK_W-1:0]  mem_wdata;
    logic [BLK_W-1:0]  mem_rdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, mem_rw, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, mem_rw, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dm_wb_cache_ctrl_line_store.sv
// dm_cache_line_store: data/tag arrays plus valid/dirty bits, async read and sync update ports
module dm_cache_line_store
    import dm_cache_pkg::*;
#(
    parameter int LINES = 4,
    parameter int TAG_W = 4,
    localparam int IDX_W = $clog2(LINES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  idx,
    output logic [BLK_W-1:0]  rdData,
    output logic [TAG_W-1:0]  rdTag,
    output logic              rdValid,
    output logic              rdDirty,
    input  logic              wordWe,
    input  logic [1:0]        wordSel,
    input  logic [WORD_W-1:0] wordData,
    input  logic              fillWe,
    input  logic [TAG_W-1:0]  fillTag,
    input  logic [BLK_W-1:0]  fillData,
    input  logic              dirtyClr
);
    logic [BLK_W-1:0] dataArr [LINES];
    logic [TAG_W-1:0] tagArr [LINES];
    logic [LINES-1:0] validBits;
    logic [LINES-1:0] dirtyBits;

    assign rdData  = dataArr[idx];
    assign rdTag   = tagArr[idx];
    assign rdValid = validBits[idx];
    assign rdDirty = dirtyBits[idx];

    // data and tags carry no reset; valid bits guard them after reset
    always_ff @(posedge clk) begin
        if (fillWe) begin
            dataArr[idx] <= fillData;
            tagArr[idx]  <= fillTag;
        end else if (wordWe) begin
            dataArr[idx] <= putWord(dataArr[idx], wordSel, wordData);
        end
    end

    // line status: refill validates clean, store dirties, write-back cleans
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validBits <= '0;
            dirtyBits <= '0;
        end else begin
            if (fillWe) begin
                validBits[idx] <= 1'b1;
                dirtyBits[idx] <= 1'b0;
            end
            if (wordWe) dirtyBits[idx] <= 1'b1;
            if (dirtyClr) dirtyBits[idx] <= 1'b0;
        end
    end
endmodule

// File: rtl/dm_wb_cache_ctrl.sv
// dm_wb_cache_ctrl: direct-mapped write-back write-allocate cache controller between CPU and block memory
module dm_wb_cache_ctrl
    import dm_cache_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LINES   = 4,
    parameter int MEM_LAT = 4
) (
    input logic clk,
    input logic rst_n,
    dm_wb_cache_ctrl_if.master bus
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              reqWrite;
    logic [ADDR_W-1:2] reqAddr;
    logic [WORD_W-1:0] reqWdata;
    logic [IDX_W-1:0]  reqIdx;
    logic [TAG_W-1:0]  reqTag;
    logic [BLK_W-1:0]  lineData;
    logic [TAG_W-1:0]  lineTag;
    logic              lineValid;
    logic              lineDirty;
    logic              hit;
    logic              lastCnt;

    assign reqIdx        = reqAddr[OFF_W +: IDX_W];
    assign reqTag        = reqAddr[ADDR_W-1 -: TAG_W];
    assign hit           = state == COMPARE && lineValid && lineTag == reqTag;
    assign lastCnt       = cnt == CNT_W'(MEM_LAT - 1);
    assign bus.req_ready = rst_n && state == IDLE;

    dm_cache_line_store #(.LINES(LINES), .TAG_W(TAG_W)) store (
        .clk      (clk),
        .rst_n    (rst_n),
        .idx      (reqIdx),
        .rdData   (lineData),
        .rdTag    (lineTag),
        .rdValid  (lineValid),
        .rdDirty  (lineDirty),
        .wordWe   (hit && reqWrite),
        .wordSel  (reqAddr[3:2]),
        .wordData (reqWdata),
        .fillWe   (state == ALLOCATE && lastCnt),
        .fillTag  (reqTag),
        .fillData (bus.mem_rdata),
        .dirtyClr (state == WRITEBACK && lastCnt)
    );

    // request capture, FSM sequencing, transfer counter and registered bus outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            reqWrite       <= 1'b0;
            reqAddr        <= '0;
            reqWdata       <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.mem_rw     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
        end else begin
            bus.resp_valid <= 1'b0;
            cnt <= ((state == WRITEBACK || state == ALLOCATE) && !lastCnt) ? cnt + CNT_W'(1) : '0;
            case (state)
                IDLE: if (bus.req_valid) begin
                    reqWrite <= bus.req_write;
                    reqAddr  <= bus.req_addr[ADDR_W-1:2];
                    reqWdata <= bus.req_wdata;
                    state    <= COMPARE;
                end
                COMPARE: if (hit) begin
                    bus.resp_valid <= 1'b1;
                    bus.resp_rdata <= reqWrite ? reqWdata : getWord(lineData, reqAddr[3:2]);
                    state          <= IDLE;
                end else if (lineValid && lineDirty) begin
                    bus.mem_rw    <= 1'b1;
                    bus.mem_addr  <= {lineTag, reqIdx, OFF_W'(0)};
                    bus.mem_wdata <= lineData;
                    state         <= WRITEBACK;
                end else begin
                    bus.mem_addr <= {reqTag, reqIdx, OFF_W'(0)};
                    state        <= ALLOCATE;
                end
                WRITEBACK: if (lastCnt) begin
                    bus.mem_rw   <= 1'b0;
                    bus.mem_addr <= {reqTag, reqIdx, OFF_W'(0)};
                    state        <= ALLOCATE;
                end
                ALLOCATE: if (lastCnt) state <= COMPARE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_wb_cache_ctrl.sv
// tb_dm_wb_cache_ctrl: scoreboarded bench pairing the cache controller with a block memory model
module tb_dm_wb_cache_ctrl;
    typedef struct {
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        int          wbCycles;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
    } exp_t;

    localparam int NV = 14;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    int           cyc = 0;
    int           nTests = 0;
    int           nFail = 0;
    int           nWrites = 0;
    logic [127:0] wrMem [64];
    logic [63:0]  wrValid = '0;
    exp_t         sbq [$];

    dm_wb_cache_ctrl_if #(.ADDR_W(10)) bus ();

    dm_wb_cache_ctrl #(.ADDR_W(10), .LINES(4), .MEM_LAT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // initial memory image; three words are pinned to the reference values
    function automatic logic [31:0] wordInit(input int wa);
        return wa == 0  ? 32'hAE252530 :
               wa == 1  ? 32'hFBE41EA3 :
               wa == 64 ? 32'h6CBCE772 :
               (32'h9E3779B9 * 32'(wa + 1)) ^ 32'h13579BDF;
    endfunction

    function automatic logic [127:0] initBlk(input int ba);
        return {wordInit(4*ba), wordInit(4*ba+1), wordInit(4*ba+2), wordInit(4*ba+3)};
    endfunction

    assign bus.mem_rdata = wrValid[bus.mem_addr[9:4]] ? wrMem[bus.mem_addr[9:4]]
                                                      : initBlk(int'(bus.mem_addr[9:4]));

    // block memory stores whatever is presented while mem_rw is high
    always @(posedge clk) begin
        if (bus.mem_rw) begin
            wrMem[bus.mem_addr[9:4]]   <= bus.mem_wdata;
            wrValid[bus.mem_addr[9:4]] <= 1'b1;
            nWrites                    <= nWrites + 1;
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.resp_valid) begin
                if (sbq.size() == 0) begin
                    nTests++;
                    nFail++;
                    $display("FAIL resp_unexpected: got resp_valid=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("resp_cycle", cyc, e.cyc);
                    chk("resp_rdata", bus.resp_rdata, e.rdata);
                end
            end
        end
    endtask

    task automatic issue(input logic wr, input logic [9:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int lat, output int t);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("issue_ready", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        t = cyc;
        sbq.push_back(exp_t'{t + lat, rdata});
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            nTests++;
            nFail++;
            $display("FAIL resp_timeout: %0d responses pending, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic runVec(input vec_t v);
        int t;
        int w0;
        w0 = nWrites;
        issue(v.wr, v.addr, v.wdata, v.rdata, v.lat, t);
        drain();
        chk("mem_writes", nWrites - w0, v.wbCycles);
    endtask

    initial begin
        vec_t vecs [NV];
        int   t;
        int   w0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        vecs[0]  = '{1'b0, 10'h000, 32'h0,        32'hAE252530,  7, 0};
        vecs[1]  = '{1'b0, 10'h004, 32'h0,        32'hFBE41EA3,  2, 0};
        vecs[2]  = '{1'b1, 10'h004, 32'hDEADBEEF, 32'hDEADBEEF,  2, 0};
        vecs[3]  = '{1'b0, 10'h004, 32'h0,        32'hDEADBEEF,  7, 0};
        vecs[4]  = '{1'b0, 10'h108, 32'h0,        wordInit(66),  7, 0};
        vecs[5]  = '{1'b0, 10'h010, 32'h0,        wordInit(4),   7, 0};
        vecs[6]  = '{1'b1, 10'h01C, 32'hCAFEF00D, 32'hCAFEF00D,  2, 0};
        vecs[7]  = '{1'b0, 10'h01F, 32'h0,        32'hCAFEF00D,  2, 0};
        vecs[8]  = '{1'b0, 10'h110, 32'h0,        wordInit(68), 11, 4};
        vecs[9]  = '{1'b0, 10'h01C, 32'h0,        32'hCAFEF00D,  7, 0};
        vecs[10] = '{1'b0, 10'h3FC, 32'h0,        wordInit(255), 7, 0};
        vecs[11] = '{1'b1, 10'h3F0, 32'h11112222, 32'h11112222,  2, 0};
        vecs[12] = '{1'b0, 10'h3F0, 32'h0,        32'h11112222,  2, 0};
        vecs[13] = '{1'b0, 10'h000, 32'h0,        32'hAE252530,  7, 0};
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_rdata", bus.resp_rdata, 0);
        chk("rst_mem_rw", bus.mem_rw, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", bus.req_ready, 1);
        for (int i = 0; i < 3; i++) runVec(vecs[i]);
        // dirty miss on index 0: write-back window then refill window
        w0 = nWrites;
        issue(1'b0, 10'h100, 32'h0, 32'h6CBCE772, 11, t);
        for (int k = 2; k <= 9; k++) begin
            while (cyc < t + k) @(negedge clk);
            chk("wb_mem_rw", bus.mem_rw, k <= 5);
            chk("wb_mem_addr", bus.mem_addr, k <= 5 ? 10'h000 : 10'h100);
            if (k <= 5) chk("wb_mem_word1", bus.mem_wdata[95:64], 32'hDEADBEEF);
        end
        drain();
        chk("wb_mem_writes", nWrites - w0, 4);
        for (int i = 3; i < NV; i++) runVec(vecs[i]);
        // request held and altered during a miss must not be re-sampled
        @(negedge clk);
        chk("held_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 10'h020;
        bus.req_wdata = 32'h0;
        t = cyc;
        sbq.push_back(exp_t'{t + 7, wordInit(8)});
        @(negedge clk);
        bus.req_write = 1'b1;
        bus.req_addr  = 10'h024;
        bus.req_wdata = 32'hBADBAD00;
        for (int k = 1; k <= 5; k++) begin
            while (cyc < t + k) @(negedge clk);
            chk("held_ready_busy", bus.req_ready, 0);
        end
        bus.req_valid = 1'b0;
        drain();
        runVec(vec_t'{1'b0, 10'h024, 32'h0, wordInit(9), 2, 0});
        // dirty line 0, then reset during the second write-back cycle
        runVec(vec_t'{1'b1, 10'h000, 32'h12345678, 32'h12345678, 2, 0});
        issue(1'b0, 10'h200, 32'h0, 32'h0, 11, t);
        while (cyc < t + 3) @(negedge clk);
        chk("wb_before_rst", bus.mem_rw, 1);
        rst_n = 1'b0;
        #1;
        sbq.delete();
        chk("rst_mid_mem_rw", bus.mem_rw, 0);
        chk("rst_mid_ready", bus.req_ready, 0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_mem_rw", bus.mem_rw, 0);
            chk("rst_hold_ready", bus.req_ready, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst2", bus.req_ready, 1);
        runVec(vec_t'{1'b0, 10'h000, 32'h0, 32'h12345678, 7, 0});
        runVec(vec_t'{1'b0, 10'h004, 32'h0, 32'hDEADBEEF, 2, 0});
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
